// File: rtl/video_out_reader.sv
// Wishbone read master that streams an 8-bit greyscale frame from RAM to a video sink,
// with a small word FIFO between the bus side and the raster timing generator.
module video_out_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int H_BLANK    = 160,
  parameter int V_ACTIVE   = 480,
  parameter int V_BLANK    = 40,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        p_clk,
  input  logic        p_resetn,
  input  logic        enable,
  input  logic [31:0] frame_base,
  output logic        irq,
  output logic        underflow,
  output logic        line_valid,
  output logic        frame_valid,
  output logic [7:0]  pixel_out,
  input  logic [31:0] p_wb_DAT_I,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I,
  input  logic        p_wb_RTY_I,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_WE_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_LOCK_O
);
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int WORDS   = H_ACTIVE * V_ACTIVE / 4;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int IW      = $clog2(WORDS + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = PW + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [IW-1:0] W_END  = IW'(WORDS);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PREFETCH, RUN, STOP} state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [31:0]     base_reg;
  logic [IW-1:0]   word_idx;
  logic            cyc_reg;
  logic            stale_reg;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_reg;
  logic [1:0]      byte_sel;
  logic            frame_valid_reg, line_valid_reg, irq_reg, underflow_reg;
  logic [7:0]      pixel_reg;

  logic            running, active, frame_end, term, fifo_empty, fifo_full;
  logic            push, pop, fetch_ok, flush;
  logic [31:0]     head;
  logic [7:0]      head_byte;

  assign running    = (state_reg == RUN);
  assign active     = running && (v_cnt < V_ACT) && (h_cnt < H_ACT);
  assign frame_end  = running && (h_cnt == '0) && (v_cnt == V_ACT);
  assign term       = cyc_reg && (p_wb_ACK_I || p_wb_ERR_I || p_wb_RTY_I);
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH);
  // A read still in flight across a frame boundary belongs to the old frame: drop its data.
  assign push       = cyc_reg && p_wb_ACK_I && !stale_reg && !frame_end;
  assign pop        = active && (byte_sel == 2'd3) && !fifo_empty;
  assign fetch_ok   = (state_reg == PREFETCH || running) && !cyc_reg && !frame_end
                      && (count_reg < DEPTH) && (word_idx < W_END);
  assign flush      = frame_end || (state_reg == STOP) || (state_reg == IDLE);
  assign head       = mem[rd_ptr];

  always_comb begin
    head_byte = head[7:0];
    case (byte_sel)
      2'd1:    head_byte = head[15:8];
      2'd2:    head_byte = head[23:16];
      2'd3:    head_byte = head[31:24];
      default: head_byte = head[7:0];
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (enable) state_next = PREFETCH;
      PREFETCH: if (!cyc_reg && (fifo_full || word_idx == W_END)) state_next = RUN;
      RUN:      if (frame_end && !enable) state_next = STOP;
      STOP:     if (!cyc_reg) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      base_reg        <= '0;
      word_idx        <= '0;
      cyc_reg         <= 1'b0;
      stale_reg       <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count_reg       <= '0;
      byte_sel        <= '0;
      frame_valid_reg <= 1'b0;
      line_valid_reg  <= 1'b0;
      irq_reg         <= 1'b0;
      underflow_reg   <= 1'b0;
      pixel_reg       <= '0;
    end else begin
      if (running) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
      end else begin
        h_cnt <= '0;
        v_cnt <= '0;
      end

      if ((state_reg == IDLE && enable) || frame_end) base_reg <= frame_base;

      if (state_reg == IDLE || frame_end) word_idx <= '0;
      else if (push)                      word_idx <= word_idx + IW'(1);

      // ERR/RTY leave word_idx alone, so the next issue repeats the same address.
      if (cyc_reg) begin
        if (term) cyc_reg <= 1'b0;
      end else if (fetch_ok) begin
        cyc_reg <= 1'b1;
      end

      if (term)                 stale_reg <= 1'b0;
      else if (frame_end && cyc_reg) stale_reg <= 1'b1;

      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count_reg <= '0;
        byte_sel  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
        // Byte slots advance with raster time even when starved, so lost pixels are not caught up.
        if (active) byte_sel <= byte_sel + 2'd1;
      end

      frame_valid_reg <= running && (v_cnt < V_ACT);
      line_valid_reg  <= active;
      irq_reg         <= frame_end;
      pixel_reg       <= (active && !fifo_empty) ? head_byte : 8'h00;

      if (state_reg == STOP)          underflow_reg <= 1'b0;
      else if (active && fifo_empty)  underflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge p_clk) begin
    if (push) mem[wr_ptr] <= p_wb_DAT_I;
  end

  assign irq         = irq_reg;
  assign underflow   = underflow_reg;
  assign line_valid  = line_valid_reg;
  assign frame_valid = frame_valid_reg;
  assign pixel_out   = pixel_reg;
  assign p_wb_ADR_O  = cyc_reg ? base_reg + (32'(word_idx) << 2) : 32'h0;
  assign p_wb_DAT_O  = 32'h0;
  assign p_wb_CYC_O  = cyc_reg;
  assign p_wb_STB_O  = cyc_reg;
  assign p_wb_WE_O   = 1'b0;
  assign p_wb_SEL_O  = 4'hF;
  assign p_wb_LOCK_O = 1'b0;
endmodule

// File: tb/tb_video_out_reader.sv
// Bench for video_out_reader: small raster, behavioural RAM slave, raster/pixel reference model.
module tb_video_out_reader;
  localparam int HA = 8, HB = 4, VA = 2, VB = 1, FD = 4;
  localparam int HT = HA + HB;
  localparam int FT = HT * (VA + VB);

  logic        p_clk = 1'b0;
  logic        p_resetn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] frame_base = 32'h0;
  logic        irq, underflow, line_valid, frame_valid;
  logic [7:0]  pixel_out;
  logic [31:0] dat_i;
  logic        ack_i, rty_i, ready;
  logic        err_i = 1'b0;
  logic [31:0] adr_o, dat_o;
  logic        cyc_o, stb_o, we_o, lock_o;
  logic [3:0]  sel_o;

  int tests = 0;
  int fails = 0;

  int          ack_delay = 0;
  int          rty_arm = 0;
  int          rty_seen = 0;
  logic [31:0] rty_adr = 32'h0;
  int          wait_cnt = 0;
  logic [31:0] log_adr[$];
  bit          log_rty[$];

  video_out_reader #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .FIFO_DEPTH(FD)) dut (
    .p_clk(p_clk), .p_resetn(p_resetn), .enable(enable), .frame_base(frame_base),
    .irq(irq), .underflow(underflow), .line_valid(line_valid), .frame_valid(frame_valid),
    .pixel_out(pixel_out),
    .p_wb_DAT_I(dat_i), .p_wb_ACK_I(ack_i), .p_wb_ERR_I(err_i), .p_wb_RTY_I(rty_i),
    .p_wb_ADR_O(adr_o), .p_wb_DAT_O(dat_o), .p_wb_CYC_O(cyc_o), .p_wb_STB_O(stb_o),
    .p_wb_WE_O(we_o), .p_wb_SEL_O(sel_o), .p_wb_LOCK_O(lock_o)
  );

  always #5 p_clk = ~p_clk;

  // RAM contents as a function of address; base 0x41000000 holds bytes 0,1,2,...
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] k;
    k = a[15:8] ^ a[23:16];
    return {(a[7:0] + 8'd3) ^ k, (a[7:0] + 8'd2) ^ k, (a[7:0] + 8'd1) ^ k, a[7:0] ^ k};
  endfunction

  assign dat_i = word_at(adr_o);
  assign ready = cyc_o && stb_o && (wait_cnt >= ack_delay);
  assign rty_i = ready && (rty_seen < rty_arm) && (adr_o == rty_adr);
  assign ack_i = ready && !rty_i;

  always @(posedge p_clk) begin
    if (cyc_o && stb_o && (ack_i || rty_i)) begin
      log_adr.push_back(adr_o);
      log_rty.push_back(rty_i);
      $display("[TB] bus %s adr=%08h", rty_i ? "rty" : "ack", adr_o);
      wait_cnt <= 0;
    end else if (cyc_o && stb_o) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
    if (rty_i) rty_seen <= rty_seen + 1;
  end

  // Reference raster: cycle c counted from the first frame_valid output.
  function automatic bit m_fv(input int c);
    return ((c % FT) / HT) < VA;
  endfunction
  function automatic bit m_lv(input int c);
    return m_fv(c) && (((c % FT) % HT) < HA);
  endfunction
  function automatic bit m_irq(input int c);
    return (c % FT) == VA * HT;
  endfunction
  function automatic logic [7:0] m_pix(input logic [31:0] base, input int c);
    int t, p;
    logic [31:0] w;
    t = c % FT;
    p = (t / HT) * HA + (t % HT);
    w = word_at(base + 32'(4 * (p / 4)));
    return w[8 * (p % 4) +: 8];
  endfunction

  task automatic do_reset();
    enable = 1'b0;
    @(negedge p_clk);
    p_resetn = 1'b0;
    repeat (3) @(negedge p_clk);
    p_resetn = 1'b1;
  endtask

  task automatic wait_fv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge p_clk);
      if (frame_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    p_resetn = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge p_clk);
    tests++;
    if ({irq, underflow, line_valid, frame_valid, pixel_out} !== 12'h0) begin
      fails++; $display("FAIL reset_outputs got=%03h want=000", {irq, underflow, line_valid, frame_valid, pixel_out});
    end
    tests++;
    if ({cyc_o, stb_o, we_o, lock_o} !== 4'h0 || adr_o !== 32'h0 || dat_o !== 32'h0) begin
      fails++; $display("FAIL reset_bus got cyc/stb/we/lock=%b adr=%08h dat=%08h want 0", {cyc_o, stb_o, we_o, lock_o}, adr_o, dat_o);
    end
    tests++;
    if (sel_o !== 4'hF) begin
      fails++; $display("FAIL reset_sel got=%h want=f", sel_o);
    end
    p_resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge p_clk);
      tests++;
      if (cyc_o !== 1'b0 || frame_valid !== 1'b0) begin
        fails++; $display("FAIL idle_quiet cycle=%0d cyc=%b fv=%b want 0", i, cyc_o, frame_valid);
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] b1, b2;
    int n0;
    bit ok;
    do_reset();
    ack_delay = 0;
    b1 = 32'h4100_0000;
    b2 = 32'h4110_0000 + (32'($urandom_range(0, 255)) << 2);
    n0 = log_adr.size();
    frame_base = b1;
    enable = 1'b1;
    wait_fv(ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL stream_start got=no frame_valid want=frame_valid within 400 cycles");
      return;
    end
    for (int c = 0; c < 100; c++) begin
      if (c == 10) frame_base = b2;
      if (c == 40) enable = 1'b0;
      tests++;
      if (c < 2 * FT) begin
        if ({frame_valid, line_valid, irq} !== {m_fv(c), m_lv(c), m_irq(c)} ||
            pixel_out !== (m_lv(c) ? m_pix(c < FT ? b1 : b2, c) : 8'h00) || underflow !== 1'b0) begin
          fails++;
          $display("FAIL stream c=%0d got fv/lv/irq=%b%b%b pix=%02h uf=%b want %b%b%b pix=%02h uf=0",
                   c, frame_valid, line_valid, irq, pixel_out, underflow, m_fv(c), m_lv(c), m_irq(c),
                   m_lv(c) ? m_pix(c < FT ? b1 : b2, c) : 8'h00);
        end
      end else if (frame_valid !== 1'b0 || cyc_o !== 1'b0) begin
        fails++; $display("FAIL stopped c=%0d got fv=%b cyc=%b want 0", c, frame_valid, cyc_o);
      end
      @(negedge p_clk);
    end
    tests++;
    if (log_adr.size() - n0 != 8) begin
      fails++; $display("FAIL stream_nreads got=%0d want=8", log_adr.size() - n0);
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (log_adr[n0 + k] !== (k < 4 ? b1 : b2) + 32'(4 * (k % 4)) || log_rty[n0 + k] !== 1'b0) begin
          fails++; $display("FAIL stream_adr k=%0d got=%08h want=%08h", k, log_adr[n0 + k], (k < 4 ? b1 : b2) + 32'(4 * (k % 4)));
        end
      end
    end
    $display("[TB] test_stream done base2=%08h", b2);
  endtask

  task automatic test_starve();
    logic [31:0] b;
    bit ok;
    do_reset();
    ack_delay = 30;
    b = 32'h4100_0000 + (32'($urandom_range(0, 63)) << 2);
    frame_base = b;
    enable = 1'b1;
    wait_fv(ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL starve_start got=no frame_valid want=frame_valid within 400 cycles");
      return;
    end
    for (int c = 0; c < 2 * FT; c++) begin
      tests++;
      if ({frame_valid, line_valid, irq} !== {m_fv(c), m_lv(c), m_irq(c)}) begin
        fails++; $display("FAIL starve_timing c=%0d got=%b%b%b want=%b%b%b", c, frame_valid, line_valid, irq, m_fv(c), m_lv(c), m_irq(c));
      end
      if (!m_lv(c) && pixel_out !== 8'h00) begin
        tests++; fails++; $display("FAIL starve_blank_pix c=%0d got=%02h want=00", c, pixel_out);
      end
      if (c < FT) begin
        tests++;
        if (pixel_out !== (m_lv(c) ? m_pix(b, c) : 8'h00) || underflow !== 1'b0) begin
          fails++; $display("FAIL starve_frame1 c=%0d got pix=%02h uf=%b want pix=%02h uf=0", c, pixel_out, underflow, m_lv(c) ? m_pix(b, c) : 8'h00);
        end
      end else if (c == FT) begin
        tests++;
        if (pixel_out !== 8'h00 || underflow !== 1'b1) begin
          fails++; $display("FAIL starve_slot got pix=%02h uf=%b want pix=00 uf=1", pixel_out, underflow);
        end
      end
      @(negedge p_clk);
    end
    tests++;
    if (underflow !== 1'b1) begin
      fails++; $display("FAIL starve_sticky got=%b want=1", underflow);
    end
    enable = 1'b0;
    $display("[TB] test_starve done base=%08h", b);
  endtask

  task automatic test_retry();
    logic [31:0] b;
    int n0;
    bit ok;
    logic [31:0] exp_adr [5];
    bit exp_rty [5];
    do_reset();
    ack_delay = 0;
    b = 32'h4100_0000;
    rty_adr = b + 32'h4;
    rty_arm = rty_seen + 1;
    exp_adr = '{b, b + 32'h4, b + 32'h4, b + 32'h8, b + 32'hC};
    exp_rty = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    n0 = log_adr.size();
    frame_base = b;
    enable = 1'b1;
    wait_fv(ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL retry_start got=no frame_valid want=frame_valid within 400 cycles");
      return;
    end
    for (int c = 0; c < FT; c++) begin
      tests++;
      if ({frame_valid, line_valid, irq} !== {m_fv(c), m_lv(c), m_irq(c)} ||
          pixel_out !== (m_lv(c) ? m_pix(b, c) : 8'h00) || underflow !== 1'b0) begin
        fails++; $display("FAIL retry_stream c=%0d got %b%b%b pix=%02h uf=%b want %b%b%b pix=%02h uf=0",
                          c, frame_valid, line_valid, irq, pixel_out, underflow, m_fv(c), m_lv(c), m_irq(c),
                          m_lv(c) ? m_pix(b, c) : 8'h00);
      end
      @(negedge p_clk);
    end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (log_adr.size() <= n0 + k) begin
        fails++; $display("FAIL retry_log k=%0d got=missing want=%08h", k, exp_adr[k]);
      end else if (log_adr[n0 + k] !== exp_adr[k] || log_rty[n0 + k] !== exp_rty[k]) begin
        fails++; $display("FAIL retry_log k=%0d got=%08h/%b want=%08h/%b", k, log_adr[n0 + k], log_rty[n0 + k], exp_adr[k], exp_rty[k]);
      end
    end
    enable = 1'b0;
    $display("[TB] test_retry done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] b;
    bit ok;
    do_reset();
    ack_delay = 30;
    b = 32'h4100_0000;
    frame_base = b;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge p_clk);
      if (cyc_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++; $display("FAIL resetmid_cyc got=no CYC_O want=CYC_O within 50 cycles");
      return;
    end
    repeat (5) @(negedge p_clk);
    p_resetn = 1'b0;
    #1;
    tests++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin
      fails++; $display("FAIL resetmid_drop got cyc=%b stb=%b want 0", cyc_o, stb_o);
    end
    enable = 1'b0;
    repeat (2) @(negedge p_clk);
    p_resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge p_clk);
      tests++;
      if (cyc_o !== 1'b0 || frame_valid !== 1'b0 || underflow !== 1'b0) begin
        fails++; $display("FAIL resetmid_idle i=%0d got cyc=%b fv=%b uf=%b want 0", i, cyc_o, frame_valid, underflow);
      end
    end
    ack_delay = 0;
    enable = 1'b1;
    wait_fv(ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL resetmid_restart got=no frame_valid want=frame_valid within 400 cycles");
      return;
    end
    for (int c = 0; c < VA * HT; c++) begin
      tests++;
      if (line_valid !== m_lv(c) || pixel_out !== (m_lv(c) ? m_pix(b, c) : 8'h00) || underflow !== 1'b0) begin
        fails++; $display("FAIL resetmid_stream c=%0d got lv=%b pix=%02h uf=%b want lv=%b pix=%02h uf=0",
                          c, line_valid, pixel_out, underflow, m_lv(c), m_lv(c) ? m_pix(b, c) : 8'h00);
      end
      @(negedge p_clk);
    end
    enable = 1'b0;
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_starve();
    test_retry();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
